mult_div_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS pipeline's execute stage. Its operands come directly from the register file read ports, `readData1` and `readData2`, as they appear in the ID/EX latch. It executes MULT, MULTU, DIV and DIVU over 33 cycles into private HI/LO registers, and supports MTHI/MTLO writes. The hazard unit stalls the pipeline on MFHI/MFLO or on a new mult/div while `busy` is high.

---
 rtl/mult_div_unit_if.sv | 23 ++
 rtl/mult_div_unit.sv | 129 ++++++++++++
 tb/tb_mult_div_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Execute-stage handshake between the pipeline and the iterative multiply/divide unit.
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        hiWrite;
  logic        loWrite;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, srcA, srcB, hiWrite, loWrite,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, srcA, srcB, hiWrite, loWrite,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO: 32 one-bit iterations plus a
// sign-fix cycle, so results land 33 cycles after launch. MTHI/MTLO are honoured only when idle.
module mult_div_unit (
  input  logic            clk,
  input  logic            rstN,
  mult_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state;
  state_t      stateNext;

  logic [1:0]  opReg;
  logic [31:0] absA;
  logic [31:0] absB;
  logic        negRes;
  logic        negRem;
  logic        divZero;
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic        doneReg;

  logic        aNeg;
  logic        bNeg;
  logic [32:0] mulSum;
  logic [63:0] mulNext;
  logic [32:0] remShift;
  logic [32:0] divTrial;
  logic [63:0] divNext;
  logic [63:0] prodFix;
  logic [31:0] quotFix;
  logic [31:0] remFix;

  assign aNeg = ~bus.op[0] & bus.srcA[31];
  assign bNeg = ~bus.op[0] & bus.srcB[31];

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.start) stateNext = RUN;
      RUN:     if (cnt == 5'd31) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Multiply: product bits shift in from the top of acc, multiplier scanned LSB first.
  // Divide: acc = {partial remainder, quotient}, dividend bits fed MSB first.
  always_comb begin
    mulSum   = {1'b0, acc[63:32]} + {1'b0, (absB[cnt] ? absA : 32'd0)};
    mulNext  = {mulSum, acc[31:1]};
    remShift = {acc[63:32], absA[~cnt]};
    divTrial = remShift - {1'b0, absB};
    if (divTrial[32]) divNext = {remShift[31:0], acc[30:0], 1'b0};
    else              divNext = {divTrial[31:0], acc[30:0], 1'b1};
  end

  always_comb begin
    prodFix = negRes ? (64'd0 - acc) : acc;
    quotFix = negRes ? (32'd0 - acc[31:0]) : acc[31:0];
    remFix  = negRem ? (32'd0 - acc[63:32]) : acc[63:32];
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      opReg   <= '0;
      absA    <= '0;
      absB    <= '0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= (state == FIX);
      case (state)
        IDLE: begin
          if (bus.hiWrite) hiReg <= bus.srcA;
          if (bus.loWrite) loReg <= bus.srcA;
          if (bus.start) begin
            opReg   <= bus.op;
            absA    <= aNeg ? (32'd0 - bus.srcA) : bus.srcA;
            absB    <= bNeg ? (32'd0 - bus.srcB) : bus.srcB;
            negRes  <= aNeg ^ bNeg;
            negRem  <= aNeg;
            divZero <= (bus.srcB == 32'd0);
            acc     <= '0;
            cnt     <= '0;
          end
        end
        RUN: begin
          acc <= opReg[1] ? divNext : mulNext;
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          if (!opReg[1]) begin
            hiReg <= prodFix[63:32];
            loReg <= prodFix[31:0];
          end else if (divZero) begin
            // Re-applying the dividend sign to its magnitude restores the original srcA.
            hiReg <= negRem ? (32'd0 - absA) : absA;
            loReg <= '1;
          end else begin
            hiReg <= remFix;
            loReg <= quotFix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = doneReg;
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if bus();

  mult_div_unit dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns {HI, LO} from plain signed/unsigned arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = $signed(a);
    sb = $signed(b);
    res = '0;
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit disturb, input bit loW);
    logic [63:0] exp;
    logic [31:0] hiHold, loHold;
    int n;
    bit stable;
    exp = model(op, a, b);
    bus.start = 1'b1; bus.op = op; bus.srcA = a; bus.srcB = b; bus.loWrite = loW;
    step();
    bus.start = 1'b0; bus.loWrite = 1'b0;
    bus.op = 2'($urandom); bus.srcA = $urandom; bus.srcB = $urandom;
    if (loW) begin
      mLo = a;
      check("mtlo_at_launch", {32'd0, bus.lo}, {32'd0, mLo});
    end
    hiHold = mHi;
    loHold = mLo;
    n = 0;
    stable = 1'b1;
    while (bus.busy === 1'b1 && n < 60) begin
      n++;
      if (bus.hi !== hiHold || bus.lo !== loHold || bus.done !== 1'b0) stable = 1'b0;
      if (disturb && n == 10) begin
        bus.start = 1'b1; bus.hiWrite = 1'b1;
      end else begin
        bus.start = 1'b0; bus.hiWrite = 1'b0;
      end
      step();
    end
    bus.start = 1'b0; bus.hiWrite = 1'b0;
    check("busy_cycles", 64'(n), 64'd33);
    check("hold_while_busy", {63'd0, stable}, 64'd1);
    mHi = exp[63:32];
    mLo = exp[31:0];
    check("done_pulse", {63'd0, bus.done}, 64'd1);
    check("result", {bus.hi, bus.lo}, {mHi, mLo});
    step();
    check("done_clear_idle", {62'd0, bus.done, bus.busy}, 64'd0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit sawDone;
    bus.start = 1'b0; bus.op = '0; bus.srcA = '0; bus.srcB = '0;
    bus.hiWrite = 1'b0; bus.loWrite = 1'b0;

    #2;
    check("reset_state", {bus.busy, bus.done, bus.hi, bus.lo}, 66'd0);
    repeat (2) @(posedge clk);
    #3 rstN = 1'b1;
    step();

    runOp(2'b01, 32'd7, 32'd6, 1'b0, 1'b0);
    runOp(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0);
    runOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    runOp(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    runOp(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    runOp(2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
    runOp(2'b10, 32'hFFFFFFFB, 32'd0, 1'b0, 1'b0);
    runOp(2'b00, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
    runOp(2'b01, 32'h00012345, 32'h00000ABC, 1'b1, 1'b0);

    // Reset in the middle of an operation.
    bus.start = 1'b1; bus.op = 2'b01; bus.srcA = 32'd9; bus.srcB = 32'd9;
    step();
    bus.start = 1'b0;
    repeat (15) step();
    rstN = 1'b0;
    #1;
    mHi = '0;
    mLo = '0;
    check("reset_mid_op", {bus.busy, bus.done, bus.hi, bus.lo}, 66'd0);
    #2 rstN = 1'b1;
    sawDone = 1'b0;
    repeat (40) begin
      step();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) sawDone = 1'b1;
    end
    check("no_done_after_reset", {63'd0, sawDone}, 64'd0);
    check("regs_after_reset", {bus.hi, bus.lo}, {mHi, mLo});

    // MTHI, then MTLO colliding with a launch.
    bus.hiWrite = 1'b1; bus.srcA = 32'h1234;
    step();
    bus.hiWrite = 1'b0;
    mHi = 32'h1234;
    check("mthi", {32'd0, bus.hi}, {32'd0, mHi});
    bus.hiWrite = 1'b1; bus.loWrite = 1'b1; bus.srcA = 32'hCAFE0001;
    step();
    bus.hiWrite = 1'b0; bus.loWrite = 1'b0;
    mHi = 32'hCAFE0001;
    mLo = 32'hCAFE0001;
    check("mthi_mtlo_both", {bus.hi, bus.lo}, {mHi, mLo});
    runOp(2'b01, 32'd2, 32'd3, 1'b0, 1'b1);

    repeat (24) begin
      runOp(2'($urandom_range(0, 3)), pickOperand(), pickOperand(), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
